// File: rtl/io_port_bank_pkg.sv
// Shared register map and status bit positions for the io_port_bank
// memory-mapped peripheral.
package io_port_bank_pkg;

  localparam logic [7:0] OUT_DATA     = 8'h00;
  localparam logic [7:0] OUT_STAT     = 8'h04;
  localparam logic [7:0] CTRL         = 8'h08;
  localparam logic [7:0] IN_DATA0     = 8'h0C;
  localparam logic [7:0] IN_STAT      = 8'h10;
  localparam logic [7:0] IN_DATA_BASE = 8'h20;

  localparam int UDF_LSB     = 16;
  localparam int OUT_OVF_BIT = 1;

  // Registers are word-addressed; the two byte-offset bits never take part in decode.
  function automatic logic [5:0] word_of(input logic [7:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-clock circular FIFO for one input channel, with synchronous flush
// that overrides push and pop in the same cycle.
module io_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(do_push);
      rptr  <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// CPU-facing I/O bank: CH buffered input channels, sticky underflow flags,
// flush control and one buffered output channel on the io_* bus.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int CH    = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       io_addr,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [31:0]      io_dout,
  output logic [31:0]      io_din,
  input  logic [CH-1:0]    in_valid,
  input  logic [CH*DW-1:0] in_data,
  output logic [CH-1:0]    in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [5:0]    word;
  logic          alive;
  logic          wr_out;
  logic          wr_ostat;
  logic          wr_ctrl;
  logic          wr_istat;
  logic          out_ovf;
  logic [CH-1:0] empty;
  logic [CH-1:0] full;
  logic [CH-1:0] flush;
  logic [CH-1:0] push;
  logic [CH-1:0] pop;
  logic [CH-1:0] hit_in;
  logic [CH-1:0] udf;
  logic [CH-1:0] unused_cnt;
  logic [DW-1:0] rdata [CH];
  logic [AW:0]   count [CH];
  logic          unused_bits;

  assign word     = word_of(io_addr);
  assign wr_out   = io_we && (word == word_of(OUT_DATA));
  assign wr_ostat = io_we && (word == word_of(OUT_STAT));
  assign wr_ctrl  = io_we && (word == word_of(CTRL));
  assign wr_istat = io_we && (word == word_of(IN_STAT));

  // in_ready is held low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush[i]),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (in_data[i*DW +: DW]),
      .rdata (rdata[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .count (count[i])
    );

    // Channel 0 is also reachable at the legacy IN_DATA0 address.
    assign hit_in[i]     = (word == 6'(word_of(IN_DATA_BASE) + i)) ||
                           ((i == 0) && (word == word_of(IN_DATA0)));
    assign in_ready[i]   = alive & ~full[i];
    assign push[i]       = in_valid[i] & in_ready[i];
    assign pop[i]        = io_re & hit_in[i];
    assign flush[i]      = wr_ctrl & io_dout[i];
    assign unused_cnt[i] = ^count[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      udf <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (io_re && hit_in[i] && empty[i])       udf[i] <= 1'b1;
        else if (wr_istat && io_dout[UDF_LSB+i])  udf[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    io_din = '0;
    if (word == word_of(OUT_STAT)) begin
      io_din[0]           = ~out_valid;
      io_din[OUT_OVF_BIT] = out_ovf;
    end else if (word == word_of(IN_STAT)) begin
      io_din[CH-1:0]       = ~empty;
      io_din[UDF_LSB +: CH] = udf;
    end
    for (int i = 0; i < CH; i++) begin
      if (hit_in[i] && !empty[i]) io_din = 32'(rdata[i]);
    end
  end

  // A write lands if the slot is free now or is being consumed this same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (wr_out) begin
        if (!out_valid || out_ready) begin
          out_data  <= io_dout[DW-1:0];
          out_valid <= 1'b1;
        end else begin
          out_ovf <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (wr_ostat && io_dout[OUT_OVF_BIT]) out_ovf <= 1'b0;
    end
  end

  assign unused_bits = ^{io_addr[1:0], io_dout, unused_cnt};

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_io_port_bank;

  localparam int CH    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [7:0]       io_addr;
  logic             io_we;
  logic             io_re;
  logic [31:0]      io_dout;
  logic [31:0]      io_din;
  logic [CH-1:0]    in_valid;
  logic [CH*DW-1:0] in_data;
  logic [CH-1:0]    in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;

  io_port_bank #(.CH(CH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_addr   (io_addr),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_dout   (io_dout),
    .io_din    (io_din),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [DW-1:0] mq [CH][$];
  logic [CH-1:0] m_udf;
  logic          m_alive;
  logic          m_ov;
  logic          m_ovf;
  logic [DW-1:0] m_od;

  logic [7:0] addr_tbl [10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_udf   = '0;
    m_alive = 1'b0;
    m_ov    = 1'b0;
    m_ovf   = 1'b0;
    m_od    = '0;
  endtask

  function automatic int chan_of(input logic [7:0] a);
    int w;
    w = int'(a) & 32'hFC;
    if (w == 12) return 0;
    if (w >= 32 && w < 32 + 4*CH) return (w - 32) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int w;
    int c;
    logic [31:0] r;
    w = int'(a) & 32'hFC;
    c = chan_of(a);
    r = '0;
    if (c >= 0) begin
      if (mq[c].size() > 0) r = 32'(mq[c][0]);
    end else if (w == 4) begin
      r = {30'b0, m_ovf, ~m_ov};
    end else if (w == 16) begin
      for (int k = 0; k < CH; k++) begin
        r[k]      = (mq[k].size() > 0);
        r[16 + k] = m_udf[k];
      end
    end
    return r;
  endfunction

  // One clock: compare outputs at the falling edge, then advance the model
  // with the same inputs the DUT sees at the rising edge.
  task automatic cycle();
    logic [CH-1:0] rdy, fl, pp, ps, us, uc;
    logic [DW-1:0] pd [CH];
    int w, hit;
    logic n_ov, n_ovf;
    logic [DW-1:0] n_od;
    @(negedge clk);
    for (int c = 0; c < CH; c++) rdy[c] = m_alive && (mq[c].size() != DEPTH);
    check("io_din", io_din, model_read(io_addr));
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    w   = int'(io_addr) & 32'hFC;
    hit = chan_of(io_addr);
    for (int c = 0; c < CH; c++) begin
      fl[c] = io_we && (w == 8) && io_dout[c];
      pp[c] = io_re && (hit == c) && (mq[c].size() > 0);
      us[c] = io_re && (hit == c) && (mq[c].size() == 0);
      uc[c] = io_we && (w == 16) && io_dout[16 + c];
      ps[c] = in_valid[c] && rdy[c];
      pd[c] = in_data[c*DW +: DW];
    end
    n_ov = m_ov; n_ovf = m_ovf; n_od = m_od;
    if (io_we && w == 0) begin
      if (!m_ov || out_ready) begin
        n_od = io_dout[DW-1:0];
        n_ov = 1'b1;
      end else begin
        n_ovf = 1'b1;
      end
    end else if (m_ov && out_ready) begin
      n_ov = 1'b0;
    end
    if (io_we && w == 4 && io_dout[1]) n_ovf = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (fl[c]) mq[c].delete();
      else begin
        if (pp[c]) void'(mq[c].pop_front());
        if (ps[c]) mq[c].push_back(pd[c]);
      end
      if (us[c]) m_udf[c] = 1'b1;
      else if (uc[c]) m_udf[c] = 1'b0;
    end
    m_ov = n_ov; m_ovf = n_ovf; m_od = n_od;
    m_alive = 1'b1;
  endtask

  task automatic idle();
    io_addr = 8'h00; io_we = 1'b0; io_re = 1'b0; io_dout = '0;
    in_valid = '0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, input logic [31:0] exp, input string tag);
    io_addr = a;
    #1;
    check(tag, io_din, exp);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    io_addr = a; io_we = 1'b1; io_dout = d;
    cycle();
    io_we = 1'b0; io_dout = '0;
  endtask

  task automatic read_reg(input logic [7:0] a, input logic [31:0] exp, input string tag);
    peek(a, exp, tag);
    io_re = 1'b1;
    cycle();
    io_re = 1'b0;
  endtask

  task automatic push_ch(input int c, input logic [DW-1:0] d);
    in_valid = '0;
    in_valid[c] = 1'b1;
    in_data[c*DW +: DW] = d;
    cycle();
    in_valid = '0;
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      io_addr  = addr_tbl[$urandom_range(0, 9)];
      io_we    = ($urandom_range(0, 3) == 0);
      io_re    = ($urandom_range(0, 1) == 1);
      io_dout  = $urandom;
      if (io_addr == 8'h08 && $urandom_range(0, 5) != 0) io_dout = '0;
      in_valid = CH'($urandom);
      in_data  = (CH*DW)'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end
    idle();
  endtask

  initial begin
    addr_tbl = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h14, 8'h28, 8'h40};
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    peek(8'h10, 32'h0, "rst_in_stat");
    #1 rst_n = 1'b1;

    // single push on channel 0, read via legacy address
    cycle();
    push_ch(0, 8'h5A);
    peek(8'h10, 32'h1, "ch0_stat_set");
    read_reg(8'h0C, 32'h5A, "ch0_legacy_read");
    peek(8'h10, 32'h0, "ch0_stat_clr");

    // fill channel 1, hold off the fifth, drain and wrap
    for (int k = 1; k <= 4; k++) push_ch(1, 8'(k));
    check("ch1_full_ready", 32'(in_ready[1]), 32'h0);
    push_ch(1, 8'h05);
    for (int k = 1; k <= 4; k++) read_reg(8'h24, 32'(k), "ch1_order");
    push_ch(1, 8'h05);
    push_ch(1, 8'h06);
    read_reg(8'h24, 32'h5, "ch1_wrap5");
    read_reg(8'h24, 32'h6, "ch1_wrap6");

    // underflow on an empty channel, then clear it
    read_reg(8'h20, 32'h0, "ch0_empty_read");
    peek(8'h10, 32'h0001_0000, "udf0_set");
    write_reg(8'h10, 32'h0001_0000);
    peek(8'h10, 32'h0, "udf0_clr");

    // output overflow, then same-cycle handshake and reload
    write_reg(8'h00, 32'hA5);
    write_reg(8'h00, 32'h3C);
    check("out_keep_first", 32'(out_data), 32'hA5);
    peek(8'h04, 32'h2, "out_stat_ovf");
    out_ready = 1'b1;
    write_reg(8'h00, 32'h77);
    out_ready = 1'b0;
    check("out_reload", 32'(out_data), 32'h77);
    check("out_still_valid", 32'(out_valid), 32'h1);
    write_reg(8'h04, 32'h2);
    peek(8'h04, 32'h0, "out_ovf_clr");
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    peek(8'h04, 32'h1, "out_drained");

    // flush wins over a simultaneous push
    push_ch(1, 8'h11);
    push_ch(1, 8'h22);
    in_valid = 2'b10;
    in_data  = {8'h33, 8'h00};
    write_reg(8'h08, 32'h2);
    in_valid = '0;
    peek(8'h10, 32'h0, "flush_stat");
    peek(8'h24, 32'h0, "flush_data");

    random_cycles(400);

    // asynchronous reset between edges
    push_ch(0, 8'hC3);
    write_reg(8'h00, 32'h99);
    #2 rst_n = 1'b0;
    io_addr = 8'h10;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h0);
    check("arst_out_data", 32'(out_data), 32'h0);
    check("arst_in_stat", io_din, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    random_cycles(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised memory-mapped I/O peripheral bank that sits on the pipelined CPU's io_addr/io_din/io_dout/io_we bus. It replaces the fixed bench-side register array, which has one hard-wired valid flag and one data byte. The bank provides CH buffered input channels with valid/ready handshakes, per-channel sticky error flags, FIFO flush control, and one buffered output channel. The existing CPU test programs keep working because the bank preserves the legacy map: data at 0x0C and status at 0x10.

## Interface
- CH, 2: number of input channels, 1..8.
- DW, 8: channel data width, 1..32; zero-extended to 32 bits on reads.
- DEPTH, 4: entries per input FIFO; power of 2, at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- io_addr  in  8  CPU byte address; bits [1:0] are ignored.
- io_we  in  1  CPU write strobe.
- io_re  in  1  CPU read strobe; pops FIFOs.
- io_dout  in  32  CPU write data.
- io_din  out  32  CPU read data; combinational from io_addr.
- in_valid  in  CH  per-channel producer valid.
- in_data  in  CH*DW  per-channel data; channel i occupies [i*DW +: DW].
- in_ready  out  CH  per-channel FIFO not full.
- out_valid  out  1  output holding register occupied.
- out_data  out  DW  output data.
- out_ready  in  1  consumer accepts out_data.

## Operation
Register map (word addresses):
- 0x00 OUT_DATA, write-only: loads the holding register when free.
- 0x04 OUT_STAT.
  - Read: bit0 = !out_valid; bit1 = out_ovf.
  - Write: writing 1 to bit1 clears out_ovf.
- 0x08 CTRL, write-only: bit i flushes FIFO i; bit i also clears ovf-free state (count := 0).
- 0x0C IN_DATA0: alias of channel 0 data.
- 0x10 IN_STAT.
  - Read: bits [CH-1:0] = FIFO i non-empty; bits [16+CH-1:16] = udf_i.
  - Write: writing 1 to bit 16+i clears udf_i.
- 0x20 + 4*i IN_DATA_i, for i < CH.
- Any other address reads 0; writes to it are ignored.

Behaviour:
- Push: when in_valid[i] && in_ready[i], in_data_i is written at the tail of FIFO i.
- Pop: when io_re hits IN_DATA of channel i:
  - FIFO non-empty: io_din = head entry, and the head advances at the edge.
  - FIFO empty: io_din = 0, nothing pops, and udf_i is set.
- Reads of any other address have no side effect.
- OUT_DATA write:
  - Slot free, or freed in the same cycle by out_valid && out_ready: out_data := io_dout[DW-1:0] and out_valid := 1.
  - Otherwise the write is dropped and out_ovf := 1.
- Handshake without a new write: out_valid := 0; out_data holds its value.
- Priority within FIFO i: flush > pop/push. On a flush cycle, the push and pop are discarded and in_ready stays as it was in that cycle.

## Timing
- Reset values while rst_n is low: in_ready = 0, out_valid = 0, out_data = 0, FIFO counts 0, out_ovf = 0, udf = 0.
- in_ready rises in the first cycle after rst_n deasserts.
- io_din is purely combinational from io_addr and FIFO head, with zero latency. This matches the MEM-stage read.
- Push-to-visible latency: 1 cycle. Data pushed at edge k is readable and IN_STAT bit i = 1 after edge k.
- in_ready[i] = (count_i != DEPTH). It is derived from registered count only, so a pop does not free space in the same cycle.
- Full FIFO with simultaneous pop and push: the push is blocked (in_ready = 0) and the pop proceeds.
- Empty FIFO with simultaneous push and read: the read returns 0 and sets udf_i; the push lands.
- Non-empty, not-full FIFO with simultaneous push and pop: count is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- An io_we and io_re in the same cycle to different registers both take effect.
- An asynchronous reset mid-operation discards all FIFO contents and the pending output immediately.

## Structure
- io_port_bank_pkg holds:
  - address constants: OUT_DATA, OUT_STAT, CTRL, IN_DATA0, IN_STAT, IN_DATA_BASE;
  - status bit positions: UDF_LSB = 16, OUT_OVF_BIT = 1.
- Sub-module io_fifo, instantiated CH times via generate:
  - parameters DW and DEPTH;
  - ports clk, rst_n, flush, push, pop, wdata, rdata, empty, full, count.
- The top level contains the address decode, read mux, sticky flags and output holding register.

## Test plan
- Reset, then drive in_valid[0] = 1 with data 0x5A for 1 cycle, then read 0x10 → bit0 = 1. Read 0x0C → 0x0000005A and pops; reading 0x10 again → 0.
- Channel 1 (DEPTH = 4): push 1, 2, 3, 4 → in_ready[1] = 0 after the 4th push. A 5th in_valid is held off. Reads of 0x24 return 1, 2, 3, 4 in order, and the pointer wrap is verified by pushing 5, 6 and reading them back.
- Read 0x20 with FIFO 0 empty → 0, and IN_STAT bit16 = 1. Write 0x10 with 0x00010000 → bit16 clears.
- Hold out_ready = 0, write 0x00 = 0xA5 then 0x3C → out_data = 0xA5, and OUT_STAT reads 0b10. Then pulse out_ready together with a write of 0x77 → out_data = 0x77 and out_valid stays 1.
- Fill FIFO 1 with 2 entries, then write CTRL = 0b10 in the same cycle as in_valid[1] → count = 0 and the pushed entry is discarded.
- Assert rst_n = 0 mid-stream, between clock edges → out_valid, in_ready and IN_STAT are 0 immediately.
